nios_cpu_irq_ctrl: RTL and testbench

Interrupt aggregator that sits directly downstream of `nios_cpu_timer_0` and the other peripheral IRQ sources. It synchronises up to 16 interrupt lines and latches them into a pending register. It masks them and presents one registered `irq` plus the lowest-numbered active source ID to the Nios CPU. Software accesses it through a 16-bit Avalon-MM slave with the same register-access timing as the timer.

---
 rtl/nios_cpu_irq_pkg.sv | 11 +
 rtl/nios_cpu_irq_sync.sv | 27 ++
 rtl/nios_cpu_irq_ctrl.sv | 79 +++++++
 tb/tb_nios_cpu_irq_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/nios_cpu_irq_pkg.sv
// nios_cpu_irq_pkg: register map and sizing constants shared by the IRQ aggregator.
package nios_cpu_irq_pkg;
  localparam logic [2:0] IRQ_ADDR_RAW = 3'd0;
  localparam logic [2:0] IRQ_ADDR_PENDING = 3'd1;
  localparam logic [2:0] IRQ_ADDR_MASK = 3'd2;
  localparam logic [2:0] IRQ_ADDR_EDGE_SEL = 3'd3;
  localparam logic [2:0] IRQ_ADDR_ACTIVE = 3'd4;
  localparam logic [2:0] IRQ_ADDR_SWI = 3'd5;
  localparam int IRQ_MAX_LINES = 16;
  localparam int IRQ_ACTIVE_BIT = 15;
endpackage

// File: rtl/nios_cpu_irq_sync.sv
// nios_cpu_irq_sync: per-bit synchroniser chain with synchronous reset; STAGES=0 passes through.
module nios_cpu_irq_sync #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_sync
      logic [WIDTH-1:0] chain [STAGES];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
          chain[0] <= d;
          for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
      end
      assign q = chain[STAGES-1];
    end
  endgenerate
endmodule

// File: rtl/nios_cpu_irq_ctrl.sv
// nios_cpu_irq_ctrl: latches, masks and prioritises up to 16 IRQ lines behind an Avalon-MM slave.
// Per-line rising-edge mode is built only when NIOS_IRQ_CTRL_EDGE_EN is defined.
module nios_cpu_irq_ctrl
  import nios_cpu_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq,
  output logic [3:0]         irq_id
);
  localparam logic [15:0] VALID = 16'((32'd1 << NUM_IRQ) - 32'd1);
  logic [NUM_IRQ-1:0] synced;
  logic [15:0] raw, pending, mask, edge_sel, active, swi, set_bits, clr_bits, rd;
  logic [3:0] id;
  logic wr;
  nios_cpu_irq_sync #(.WIDTH(NUM_IRQ), .STAGES(IRQ_SYNC_STAGES)) u_sync (
    .clk(clk), .reset(reset), .d(irq_in), .q(synced)
  );
  always_comb begin
    raw = '0;
    raw[NUM_IRQ-1:0] = synced;
  end
  assign wr = chipselect && !write_n;
  assign swi = (wr && address == IRQ_ADDR_SWI) ? writedata : '0;
  assign clr_bits = (wr && address == IRQ_ADDR_PENDING) ? writedata : '0;
`ifdef NIOS_IRQ_CTRL_EDGE_EN
  logic [15:0] prev;
  // edge-mode lines only set on a 0->1 transition of the synced level
  assign set_bits = ((raw & ~(edge_sel & prev)) | swi) & VALID;
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
      edge_sel <= '0;
    end else begin
      prev <= raw;
      if (wr && address == IRQ_ADDR_EDGE_SEL) edge_sel <= writedata & VALID;
    end
  end
`else
  assign edge_sel = '0;
  assign set_bits = (raw | swi) & VALID;
`endif
  assign active = pending & mask;
  always_comb begin
    id = '0;
    for (int i = IRQ_MAX_LINES - 1; i >= 0; i--) if (active[i]) id = 4'(i);
  end
  always_comb begin
    rd = address == IRQ_ADDR_RAW      ? raw :
         address == IRQ_ADDR_PENDING  ? pending :
         address == IRQ_ADDR_MASK     ? mask :
         address == IRQ_ADDR_EDGE_SEL ? edge_sel :
         address == IRQ_ADDR_ACTIVE   ? {irq, 11'd0, irq_id} : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      mask <= '0;
      irq <= 1'b0;
      irq_id <= '0;
      readdata <= '0;
    end else begin
      pending <= set_bits | (pending & ~clr_bits);
      if (wr && address == IRQ_ADDR_MASK) mask <= writedata & VALID;
      irq <= |active;
      irq_id <= id;
      readdata <= rd;
    end
  end
endmodule

// File: tb/tb_nios_cpu_irq_ctrl.sv
// tb_nios_cpu_irq_ctrl: directed + random stimulus, scoreboard against a cycle reference model.
module tb_nios_cpu_irq_ctrl;
  localparam int N = 8;
  localparam int S = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] irq_in = '0;
  logic [2:0] address = '0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic irq;
  logic [3:0] irq_id;
  int n_chk = 0;
  int n_fail = 0;

  nios_cpu_irq_ctrl #(.NUM_IRQ(N), .IRQ_SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // reference model: architectural state, updated with the register rules once per clock
  logic [15:0] m_pend, m_mask, m_edge, m_prev, m_raw, m_rd, m_act, m_newp;
  logic [15:0] hist [0:2];
  logic m_irq, m_irq_n;
  logic [3:0] m_id, m_id_n;
  logic [20:0] exp_q [$];

  always @(posedge clk) begin
    if (reset) begin
      m_pend = '0; m_mask = '0; m_edge = '0; m_prev = '0;
      for (int i = 0; i < 3; i++) hist[i] = '0;
      m_irq = 1'b0; m_id = '0;
      exp_q.push_back(21'd0);
    end else begin
      m_raw = (S == 0) ? {8'h00, irq_in} : hist[S-1];
      m_act = m_pend & m_mask;
      case (address)
        3'd0: m_rd = m_raw;
        3'd1: m_rd = m_pend;
        3'd2: m_rd = m_mask;
        3'd3: m_rd = m_edge;
        3'd4: m_rd = {m_irq, 11'd0, m_id};
        default: m_rd = '0;
      endcase
      m_irq_n = (m_act != 0);
      m_id_n = '0;
      for (int i = 15; i >= 0; i--) if (m_act[i]) m_id_n = 4'(i);
      m_newp = m_pend;
      for (int i = 0; i < N; i++) begin
        logic s;
        s = m_edge[i] ? (m_raw[i] && !m_prev[i]) : m_raw[i];
        if (chipselect && !write_n && address == 3'd5 && writedata[i]) s = 1'b1;
        if (s) m_newp[i] = 1'b1;
        else if (chipselect && !write_n && address == 3'd1 && writedata[i]) m_newp[i] = 1'b0;
      end
      if (chipselect && !write_n && address == 3'd2) m_mask = writedata & 16'h00FF;
`ifdef NIOS_IRQ_CTRL_EDGE_EN
      if (chipselect && !write_n && address == 3'd3) m_edge = writedata & 16'h00FF;
`endif
      for (int i = 2; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {8'h00, irq_in};
      m_prev = m_raw;
      m_pend = m_newp;
      m_irq = m_irq_n;
      m_id = m_id_n;
      exp_q.push_back({m_rd, m_irq, m_id});
    end
  end

  always @(posedge clk) begin
    logic [20:0] e;
    #1;
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard: no expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("readdata", readdata, e[20:5]);
      chk("irq", {15'd0, irq}, {15'd0, e[4]});
      chk("irq_id", {12'd0, irq_id}, {12'd0, e[3:0]});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    reset = 1'b0;
    bus_wr(3'd2, 16'h0001);
    irq_in = 8'h01;
    tick(5);
    chk("timer_irq", {15'd0, irq}, 16'd1);
    chk("timer_id", {12'd0, irq_id}, 16'd0);
    bus_wr(3'd1, 16'h0001);
    address = 3'd1;
    tick(2);
    chk("w1c_level_hold", readdata, 16'h0001);
    irq_in = 8'h00;
    tick(4);
    bus_wr(3'd1, 16'hFFFF);
    bus_wr(3'd2, 16'h00FF);
    irq_in = 8'h28;
    tick(5);
    address = 3'd4;
    tick(1);
    chk("active_read", readdata, 16'h8003);
    bus_wr(3'd2, 16'h00F0);
    tick(1);
    chk("prio_after_mask", {12'd0, irq_id}, 16'd5);
    irq_in = 8'h00;
    tick(4);
    bus_wr(3'd1, 16'hFFFF);
`ifdef NIOS_IRQ_CTRL_EDGE_EN
    bus_wr(3'd3, 16'h0004);
    irq_in = 8'h04;
    tick(2);
    irq_in = 8'h00;
    tick(4);
    address = 3'd1;
    tick(1);
    chk("edge_latched", readdata, 16'h0004);
    bus_wr(3'd1, 16'h0004);
    tick(1);
    chk("edge_cleared", readdata, 16'h0000);
    bus_wr(3'd3, 16'h0000);
`endif
    irq_in = 8'h02;
    repeat (4) bus_wr(3'd1, 16'h0002);
    address = 3'd1;
    tick(1);
    chk("collision", readdata & 16'h0002, 16'h0002);
    irq_in = 8'h00;
    tick(4);
    bus_wr(3'd1, 16'hFFFF);
    bus_wr(3'd2, 16'h0080);
    bus_wr(3'd5, 16'h0080);
    tick(1);
    chk("swi_irq", {15'd0, irq}, 16'd1);
    chk("swi_id", {12'd0, irq_id}, 16'd7);
    chk("swi_read0", readdata, 16'h0000);
    bus_wr(3'd5, 16'h00FF);
    bus_wr(3'd2, 16'h00FF);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rst_irq", {15'd0, irq}, 16'd0);
    chk("rst_id", {12'd0, irq_id}, 16'd0);
    chk("rst_rd", readdata, 16'h0000);
    address = 3'd1;
    tick(2);
    chk("rst_pending", readdata, 16'h0000);
    address = 3'd6;
    tick(1);
    chk("addr6", readdata, 16'h0000);
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = N'($urandom);
      chipselect = $urandom_range(0, 1) == 1;
      write_n = $urandom_range(0, 2) == 0;
      address = 3'($urandom_range(0, 7));
      writedata = 16'($urandom & $urandom);
      reset = $urandom_range(0, 199) == 0;
      tick(1);
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
